// File: rtl/r2sdf_bf_stage.sv
// Radix-2 SDF butterfly stage: first half-frame is parked in external delay FIFOs,
// second half emits half-scaled sums while the differences recirculate through the FIFOs.
`timescale 1ns/1ps
module r2sdf_bf_stage #(
    parameter int WIDTH     = 11,
    parameter int HALF_LOG2 = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_re,
    input  logic [WIDTH-1:0]     in_im,
    output logic                 in_ready,
    input  logic                 flush,
    output logic                 fifo_w_en,
    output logic                 fifo_r_en,
    output logic [WIDTH-1:0]     fifo_re_wdata,
    output logic [WIDTH-1:0]     fifo_im_wdata,
    input  logic [WIDTH-1:0]     fifo_re_rdata,
    input  logic [WIDTH-1:0]     fifo_im_rdata,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_re,
    output logic [WIDTH-1:0]     out_im,
    output logic                 out_sel,
    output logic [HALF_LOG2-1:0] out_idx
);

    typedef enum logic [1:0] {FILL, BFLY, PASS, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [HALF_LOG2-1:0] cnt_q, cnt_d;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     out_re_q, out_im_q;
    logic                 out_sel_q;
    logic [HALF_LOG2-1:0] out_idx_q;

    logic             accept, step, cnt_wrap, butterfly, produce;
    logic [WIDTH-1:0] sum_re, sum_im, diff_re, diff_im;

    // Sign-extend by one bit so the sum cannot overflow, then floor-divide by two.
    function automatic logic [WIDTH-1:0] half_op(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic             sub);
        logic signed [WIDTH:0] ea;
        logic signed [WIDTH:0] eb;
        logic signed [WIDTH:0] r;
        ea = {a[WIDTH-1], a};
        eb = {b[WIDTH-1], b};
        r  = sub ? (ea - eb) : (ea + eb);
        return WIDTH'(r >>> 1);
    endfunction

    assign accept    = in_valid && (state_q != DRAIN);
    assign step      = accept || (state_q == DRAIN);
    assign cnt_wrap  = (cnt_q == {HALF_LOG2{1'b1}});
    assign butterfly = (state_q == BFLY);

    assign sum_re  = half_op(fifo_re_rdata, in_re, 1'b0);
    assign sum_im  = half_op(fifo_im_rdata, in_im, 1'b0);
    assign diff_re = half_op(fifo_re_rdata, in_re, 1'b1);
    assign diff_im = half_op(fifo_im_rdata, in_im, 1'b1);

    assign in_ready      = (state_q != DRAIN);
    assign fifo_w_en     = accept;
    assign fifo_r_en     = (accept && (state_q != FILL)) || (state_q == DRAIN);
    assign fifo_re_wdata = butterfly ? diff_re : in_re;
    assign fifo_im_wdata = butterfly ? diff_im : in_im;
    // Every FIFO read yields exactly one output sample.
    assign produce       = fifo_r_en;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (step) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_wrap) begin
                case (state_q)
                    FILL:    state_d = BFLY;
                    BFLY:    state_d = PASS;
                    PASS:    state_d = BFLY;
                    default: state_d = FILL;
                endcase
            end
        end else if ((state_q == PASS) && (cnt_q == '0) && flush && !in_valid) begin
            state_d = DRAIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_sel_q   <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= produce;
            if (produce) begin
                out_re_q  <= butterfly ? sum_re : fifo_re_rdata;
                out_im_q  <= butterfly ? sum_im : fifo_im_rdata;
                out_sel_q <= !butterfly;
                out_idx_q <= cnt_q;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_sel   = out_sel_q;
    assign out_idx   = out_idx_q;

endmodule

// File: doc/r2sdf_bf_stage.md
Name: r2sdf_bf_stage

Overview:
Radix-2 single-path delay-feedback (R2SDF) butterfly stage, first stage of the 64-point FFT pipeline. It drives and consumes a pair of external 32-deep, 11-bit delay FIFOs, one for the real part and one for the imaginary part. Complex samples enter at one per valid cycle. The stage emits half-scaled butterfly sums and differences to the downstream twiddle multiplier, tagging each sample as sum or difference.

Parameters:
WIDTH, 11, signed sample component width (matches delay FIFO width)
HALF_LOG2, 5, log2 of half frame (delay depth 32; frame length 64)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input sample strobe
in_re  in  WIDTH  input real part, signed
in_im  in  WIDTH  input imag part, signed
in_ready  out  1  stage accepts input (low only in DRAIN)
flush  in  1  pulse: drain pending differences at frame boundary
fifo_w_en  out  1  write enable, shared by both FIFOs
fifo_r_en  out  1  read enable, shared by both FIFOs
fifo_re_wdata  out  WIDTH  real data to FIFO
fifo_im_wdata  out  WIDTH  imag data to FIFO
fifo_re_rdata  in  WIDTH  real FIFO head (combinational, valid while r_en high)
fifo_im_rdata  in  WIDTH  imag FIFO head
out_valid  out  1  output strobe
out_re  out  WIDTH  output real part
out_im  out  WIDTH  output imag part
out_sel  out  1  0 = sum sample, 1 = difference sample (needs twiddle)
out_idx  out  HALF_LOG2  sample index within the half-frame

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk. The FIFOs share this reset, so their indices realign with the stage.
- At reset: state=FILL, cnt=0, out_valid=0, out_re=0, out_im=0, out_sel=0, out_idx=0.
- cnt (HALF_LOG2 bits) increments on each accepted input in FILL/BFLY/PASS, and on every cycle in DRAIN. It wraps 31->0, and the wrap moves the FSM to the next state.
- FIFO outputs are combinational:
  - fifo_w_en=1 and fifo_r_en as listed per state; both are 0 in any cycle with no transfer.
- FILL (first half of first frame):
  - on in_valid: w_en=1, r_en=0, wdata=input; no output.
  - cnt wrap -> BFLY.
- BFLY (second half):
  - on in_valid: r_en=1, w_en=1.
  - Let a=FIFO head, b=input.
  - Output sum=(a+b)>>>1.
  - Write diff=(a-b)>>>1 to the FIFO.
  - out_sel=0.
  - cnt wrap -> PASS.
- PASS (first half of a subsequent frame):
  - on in_valid: r_en=1, w_en=1.
  - Output the FIFO head unchanged with out_sel=1.
  - Write the input to the FIFO.
  - cnt wrap -> BFLY.
- DRAIN:
  - Entered when flush=1 while state=PASS and cnt=0 and in_valid=0.
  - Every cycle: r_en=1, w_en=0; output FIFO head, out_sel=1.
  - in_ready=0; in_valid is ignored.
  - cnt wrap -> FILL.
- flush in any other condition is ignored.
- Arithmetic:
  - Compute in WIDTH+1 bits with sign extension, then take bits [WIDTH:1] (arithmetic shift with floor). No saturation is needed.
- Output timing:
  - Outputs are registered with 1-cycle latency from the transfer cycle.
  - out_idx = cnt value at transfer.
  - out_valid=1 only in the cycle after a producing transfer; otherwise 0.
  - out_re/out_im hold their last value when out_valid=0.
- Pointer invariant: after FILL, FIFO occupancy is exactly 32. BFLY and PASS read and write every transfer, so occupancy is preserved. DRAIN empties the FIFO, so FILL restarts clean.
- Input stalls (in_valid=0) freeze cnt and state in FILL/BFLY/PASS; no FIFO access occurs.
- Reset mid-frame discards all pending data; the next sample is treated as frame start in FILL.

Test Plan:
- Reset check: assert rst_n=0 mid-BFLY -> all outputs 0, state FILL, w_en=r_en=0; the next 32 samples produce no output.
- Ramp frame: in_re=n (n=0..63), in_im=0, continuous.
  - Samples 32..63 -> out_re=n-16 (16..47), out_sel=0, out_idx=0..31.
  - Then flush -> 32 DRAIN outputs with out_re=-16, out_im=0, out_sel=1, in_ready=0, then FILL.
- Back-to-back frames: two ramp frames with no gap.
  - During frame 2's first half, outputs are -16 with out_sel=1, and fifo_w_en=r_en=1 each cycle.
  - Frame 2's second half gives sums 16..47 again.
- Extremes:
  - a=1023, b=1023 -> sum 1023, diff 0.
  - a=-1024, b=1023 -> sum -1, stored diff -1024.
  - a=-1024, b=-1024 -> sum -1024.
- Stalls: random in_valid gaps through BFLY -> same output values as the continuous ramp, each 1 cycle after its accepted input; no FIFO enables during gaps.
- Illegal flush: flush pulses in FILL, in BFLY, and in PASS with cnt=5 -> ignored, no state change, in_ready stays 1.
